// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide engine returning {hi,lo}.
// Define MULDIV_ACC_EN to enable MADD/MSUB accumulation on ops 4-7.
module ex_muldiv_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    input  logic [DATA_W-1:0]   hi_i,
    input  logic [DATA_W-1:0]   lo_i,
    input  logic                flush,
    input  logic                hold_i,
    output logic                stallreq,
    output logic                busy,
    output logic                result_valid,
    output logic [2*DATA_W-1:0] result,
    output logic                div_zero
);
    localparam int W  = DATA_W;
    localparam int CW = $clog2(DATA_W + MUL_LAT + 2);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_n;

    logic          uns_q, neg_q, neg_r, dz_q;
    logic [W-1:0]  a_q, b_q, rem_q, quo_q, dvs_q;
    logic [CW-1:0] cnt, mul_end;
    logic          acc_in;

`ifdef MULDIV_ACC_EN
    logic          acc_q, sub_q;
    logic [2*W-1:0] acc_val_q;
    assign acc_in  = op[2];
    assign mul_end = CW'(MUL_LAT - 1) + CW'(acc_q);
`else
    assign acc_in  = 1'b0;
    assign mul_end = CW'(MUL_LAT - 1);
`endif

    logic accept, is_div_in, mul_short, in_neg_a, in_neg_b;
    assign accept    = (state == IDLE) && start && !flush;
    assign is_div_in = (op[2:1] == 2'b01);
    assign mul_short = (MUL_LAT == 1) && !acc_in;
    assign in_neg_a  = !op[0] && opa[W-1];
    assign in_neg_b  = !op[0] && opb[W-1];

    // Multiplier reads the ports directly only for the single-cycle case from IDLE.
    logic           m_uns;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] ea, eb, prod, mul_res;
    always_comb begin
        m_uns = uns_q;
        m_a   = a_q;
        m_b   = b_q;
        if (state == IDLE) begin
            m_uns = op[0];
            m_a   = opa;
            m_b   = opb;
        end
        ea      = {{W{!m_uns && m_a[W-1]}}, m_a};
        eb      = {{W{!m_uns && m_b[W-1]}}, m_b};
        prod    = ea * eb;
        mul_res = prod;
`ifdef MULDIV_ACC_EN
        if (acc_q) mul_res = sub_q ? acc_val_q - prod : acc_val_q + prod;
`endif
    end

    // One restoring step; a clear top bit of diff means the divisor fit.
    logic [W:0]   shifted, diff;
    logic         ge;
    logic [W-1:0] rem_n, quo_n, q_fix, r_fix;
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = !diff[W];
        rem_n   = ge ? diff[W-1:0] : shifted[W-1:0];
        quo_n   = {quo_q[W-2:0], ge};
        q_fix   = neg_q ? -quo_n : quo_n;
        r_fix   = neg_r ? -rem_n : rem_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) begin
                if (is_div_in) state_n = (opb == '0) ? DONE : DIV;
                else           state_n = mul_short ? DONE : MUL;
            end
            MUL:  if (cnt == mul_end) state_n = DONE;
            DIV:  if (cnt == CW'(W - 1)) state_n = DONE;
            DONE: if (!hold_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uns_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt    <= '0;
            result <= '0;
`ifdef MULDIV_ACC_EN
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
            acc_val_q <= '0;
`endif
        end else if (!flush) begin
            case (state)
                IDLE: if (accept) begin
                    uns_q <= op[0];
                    a_q   <= opa;
                    b_q   <= opb;
                    neg_q <= in_neg_a ^ in_neg_b;
                    neg_r <= in_neg_a;
                    rem_q <= '0;
                    quo_q <= in_neg_a ? -opa : opa;
                    dvs_q <= in_neg_b ? -opb : opb;
                    dz_q  <= 1'b0;
                    cnt   <= is_div_in ? CW'(0) : CW'(1);
`ifdef MULDIV_ACC_EN
                    acc_q     <= op[2];
                    sub_q     <= op[1];
                    acc_val_q <= {hi_i, lo_i};
`endif
                    if (is_div_in && opb == '0) begin
                        result <= {opa, {W{1'b1}}};
                        dz_q   <= 1'b1;
                    end else if (!is_div_in && mul_short) begin
                        result <= mul_res;
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == mul_end) result <= mul_res;
                end
                DIV: begin
                    cnt   <= cnt + 1'b1;
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    if (cnt == CW'(W - 1)) result <= {r_fix, q_fix};
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign div_zero     = (state == DONE) && dz_q;
    assign stallreq     = reset && start && !flush && (state != DONE);

`ifndef MULDIV_ACC_EN
    logic unused_ok;
    assign unused_ok = ^{hi_i, lo_i};
`endif
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed ops push expectations, a monitor pops on result_valid.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, flush, hold_i;
    logic [2:0]  op;
    logic [31:0] opa, opb, hi_i, lo_i;
    logic        stallreq, busy, result_valid, div_zero;
    logic [63:0] result;

    ex_muldiv_unit #(.DATA_W(32), .MUL_LAT(2)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .hi_i(hi_i), .lo_i(lo_i), .flush(flush), .hold_i(hold_i),
        .stallreq(stallreq), .busy(busy), .result_valid(result_valid),
        .result(result), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] res; logic dz; int due;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin bad++; $display("FAIL %s: got %h want %h", nm, act, exp); end
    endtask
    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin bad++; $display("FAIL %s: got %b want %b", nm, act, exp); end
    endtask
    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin bad++; $display("FAIL %s: got %0d want %0d", nm, act, exp); end
    endtask

    // Monitor: first valid cycle pops and checks; later valid cycles must hold the result.
    logic        prev_v = 1'b0;
    logic [63:0] last_res = '0;
    always @(negedge clk) begin
        if (result_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_result: got %h want none", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk64("result", result, e.res);
                chk1("div_zero", div_zero, e.dz);
                chki("latency_cycle", cyc, e.due);
            end
            last_res = result;
        end else if (result_valid) begin
            chk64("result_held", result, last_res);
        end
        prev_v = result_valid;
    end

    // Called at #1 after a posedge; returns at #1 after the posedge that leaves DONE.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input logic [63:0] er,
                          input logic edz, input int lat, input int hc);
        exp_t e;
        bit got = 0;
        int n = 0;
        op = o; opa = a; opb = b; hi_i = h; lo_i = l; start = 1'b1; hold_i = (hc > 1);
        e.res = er; e.dz = edz; e.due = cyc + lat;
        exp_q.push_back(e);
        while (!got && n < 80) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1;
                chk1("stall_in_done", stallreq, 1'b0);
            end else begin
                chk1("stall_pending", stallreq, 1'b1);
                @(posedge clk); #1;
            end
            n++;
        end
        if (!got) begin total++; bad++; $display("FAIL timeout: got no result_valid want one"); end
        for (int k = 1; k < hc; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1("hold_valid", result_valid, 1'b1);
        end
        hold_i = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 0; flush = 0; hold_i = 0; op = 0;
        opa = 0; opb = 0; hi_i = 0; lo_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_valid", result_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk64("rst_result", result, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 2, 1);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0, 64'h00000002_FFFFFFFA, 1'b0, 2, 1);
        run_op(3'd0, 32'd7, 32'd6, 0, 0, 64'd42, 1'b0, 2, 1);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33, 1);
        run_op(3'd3, 32'h12345678, 32'd0, 0, 0, 64'h12345678_FFFFFFFF, 1'b1, 1, 1);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 64'h00000000_80000000, 1'b0, 33, 1);
        run_op(3'd2, 32'd7, 32'hFFFFFFFE, 0, 0, 64'h00000001_FFFFFFFD, 1'b0, 33, 1);
        run_op(3'd3, 32'hFFFFFFFF, 32'h10, 0, 0, 64'h0000000F_0FFFFFFF, 1'b0, 33, 1);

        // Flush a DIV in its cycle 10
        op = 3'd2; opa = 32'd1000; opb = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1; flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_valid", result_valid, 1'b0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (result_valid) seen = 1; end
        chk1("flush_no_result", seen, 1'b0);
        @(posedge clk); #1;
        run_op(3'd3, 32'd100, 32'd7, 0, 0, {32'd2, 32'd14}, 1'b0, 33, 1);

        // Flush together with start in IDLE
        op = 3'd0; opa = 32'd3; opb = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk1("flush_idle_stall", stallreq, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk1("flush_idle_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Hold in DONE for 3 cycles with start high
        run_op(3'd1, 32'd5, 32'd6, 0, 0, 64'd30, 1'b0, 2, 3);
        @(negedge clk);
        chk1("after_hold_busy", busy, 1'b0);
        @(posedge clk); #1;

`ifdef MULDIV_ACC_EN
        run_op(3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5, 64'h4, 1'b0, 3, 1);
        run_op(3'd7, 32'd3, 32'd2, 32'd0, 32'd10, 64'd4, 1'b0, 3, 1);
        run_op(3'd6, 32'd2, 32'd3, 32'd0, 32'd1, 64'hFFFFFFFF_FFFFFFFB, 1'b0, 3, 1);
`else
        run_op(3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 2, 1);
        run_op(3'd7, 32'd3, 32'd2, 32'd0, 32'd10, 64'd6, 1'b0, 2, 1);
        run_op(3'd5, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5, 64'h00000001_FFFFFFFE, 1'b0, 2, 1);
`endif

        // Async reset in cycle 5 of a DIV
        op = 3'd2; opa = 32'd50; opb = 32'd7; start = 1'b1;
        repeat (5) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        chk1("arst_valid", result_valid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_stall", stallreq, 1'b0);
        chk1("arst_dz", div_zero, 1'b0);
        chk64("arst_result", result, 64'h0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(negedge clk); if (result_valid) seen = 1; end
        chk1("arst_no_result", seen, 1'b0);

        chki("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
